multicycle_ctrl: RTL and testbench

Moore/Mealy FSM sequencing a multi-cycle RV32I datapath that shares one memory port between instruction fetch and data access. It drives datapath select and enable lines from IR opcode/funct fields. It handles the memory req/ready handshake with a timeout and halts on an illegal opcode or a bus timeout. Supported classes: R-type, I-ALU, LW, SW, BEQ/BNE, JAL.

---
 rtl/riscv_mc_pkg.sv | 51 +++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller: state enum,
// opcode constants, datapath select encodings and the I-type ALU op helper.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EX_ALU,
    S_ALU_WB,
    S_EX_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_LOAD_WB,
    S_EX_BR,
    S_JUMP,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // funct7[5] is only an opcode modifier for SRAI; elsewhere it is imm[10].
  function automatic logic [3:0] imm_alu_op(input logic [2:0] f3, input logic f7_5);
    return {(f3 == 3'b101) & f7_5, f3};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the wait cycle that would reach MEM_TIMEOUT.
// MEM_TIMEOUT=0 never expires; clear has priority over counting.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (MEM_TIMEOUT != 0) && count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sharing one memory port; 3-5 cycles/instr plus memory waits.
// Holds mem_req until mem_ready, halts on illegal opcode or timeout; PERF_CNT_EN adds counters.
module multicycle_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       aluout_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       halted,
`ifdef PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [1:0] err
);

  state_e     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic       tmo_expired;
  logic       br_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign br_taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_d != state_q),
    .count_en (mem_req & ~mem_ready),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (tmo_expired) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_IMM:      state_d = S_EX_ALU;
          OP_LOAD, OP_STORE: state_d = S_EX_ADDR;
          OP_BRANCH:         state_d = S_EX_BR;
          OP_JAL:            state_d = S_JUMP;
          default:           begin state_d = S_HALT; err_d = ERR_ILLEGAL; end
        endcase
      end
      S_EX_ALU:  state_d = S_ALU_WB;
      S_EX_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)        state_d = S_LOAD_WB;
        else if (tmo_expired) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
      end
      S_MEM_WR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (tmo_expired) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
      end
      S_ALU_WB, S_LOAD_WB, S_EX_BR, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    aluout_write = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    halted       = (state_q == S_HALT);
    err          = err_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
      end
      S_EX_ALU: begin
        alu_src_a    = SRCA_RS1;
        aluout_write = 1'b1;
        if (opcode == OP_R) begin
          alu_op = {funct7[5], funct3};
        end else begin
          alu_src_b = SRCB_IMM;
          alu_op    = imm_alu_op(funct3, funct7[5]);
        end
      end
      S_ALU_WB:  reg_write = 1'b1;
      S_EX_ADDR: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      S_EX_BR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = br_taken;
        pc_src    = br_taken;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_RST && state_q != S_HALT)
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
        instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction model expands each instruction
// into its expected per-cycle control words and memory-ready schedule.
module tb_multicycle_ctrl;
  import riscv_mc_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       aluout_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic       reg_write;
    logic [1:0] wb;
    logic       halted;
    logic [1:0] err;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, aluout_write;
  logic [1:0] alu_src_a, alu_src_b, wb_sel, err;
  logic [3:0] alu_op;
  logic       reg_write, halted;
`ifdef PERF_CNT_EN
  logic [31:0] perf_unused_cyc, perf_unused_ret;
`endif

  ctl_t got_c;
  assign got_c = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, aluout_write,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, halted, err};

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .aluout_write(aluout_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .halted(halted),
`ifdef PERF_CNT_EN
    .cycle_cnt(perf_unused_cyc), .instret_cnt(perf_unused_ret),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  ctl_t exp_q[$];
  bit   rdy_q[$];
  string tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input string tag, input bit rdy, input ctl_t c);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
    tag_q.push_back(tag);
  endfunction

  function automatic void push_halt(input logic [1:0] code, input int n);
    ctl_t c;
    for (int k = 0; k < n; k++) begin
      c = '0;
      c.halted = 1'b1;
      c.err = code;
      push("HALT", bit'($urandom_range(0, 1)), c);
    end
  endfunction

  // Memory phase: 'waits' cycles of ready low, then one ready-high cycle; returns 1 on timeout.
  function automatic bit mem_phase(input string tag, input bit we, input bit asel,
                                   input bit fetch, input int waits);
    ctl_t c;
    for (int i = 0; i <= waits; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      c.mem_we = we;
      c.addr_sel = asel;
      if (i == waits) begin
        if (fetch) begin
          c.ir_write = 1'b1;
          c.b = 2'b10;
          c.pc_write = 1'b1;
        end
        push(tag, 1'b1, c);
        return 1'b0;
      end
      push(tag, 1'b0, c);
      if (TMO != 0 && i + 1 == TMO) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_instr(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input bit z,
                                     input int wf, input int wm, input int halt_n);
    ctl_t c;
    bit   taken;
    if (mem_phase("FETCH", 1'b0, 1'b0, 1'b1, wf)) begin
      push_halt(2'b10, halt_n);
      return 1'b1;
    end
    c = '0; c.a = 2'b01; c.b = 2'b01; c.aluout_write = 1'b1;
    push("DECODE", bit'($urandom_range(0, 1)), c);
    case (op)
      7'b0110011, 7'b0010011: begin
        c = '0; c.a = 2'b10; c.aluout_write = 1'b1;
        if (op == 7'b0110011) begin
          c.b = 2'b00; c.op = {f7[5], f3};
        end else begin
          c.b = 2'b01; c.op = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
        end
        push("EX_ALU", bit'($urandom_range(0, 1)), c);
        c = '0; c.reg_write = 1'b1;
        push("ALU_WB", bit'($urandom_range(0, 1)), c);
      end
      7'b0000011, 7'b0100011: begin
        c = '0; c.a = 2'b10; c.b = 2'b01; c.aluout_write = 1'b1;
        push("EX_ADDR", bit'($urandom_range(0, 1)), c);
        if (mem_phase((op == 7'b0100011) ? "MEM_WR" : "MEM_RD", op == 7'b0100011,
                      1'b1, 1'b0, wm)) begin
          push_halt(2'b10, halt_n);
          return 1'b1;
        end
        if (op == 7'b0000011) begin
          c = '0; c.reg_write = 1'b1; c.wb = 2'b01;
          push("LOAD_WB", bit'($urandom_range(0, 1)), c);
        end
      end
      7'b1100011: begin
        taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        c = '0; c.a = 2'b10; c.b = 2'b00; c.op = 4'b1000;
        c.pc_write = taken; c.pc_src = taken;
        push("EX_BR", bit'($urandom_range(0, 1)), c);
      end
      7'b1101111: begin
        c = '0; c.reg_write = 1'b1; c.wb = 2'b10; c.pc_write = 1'b1; c.pc_src = 1'b1;
        push("JUMP", bit'($urandom_range(0, 1)), c);
      end
      default: begin
        push_halt(2'b01, halt_n);
        return 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  task automatic run_q(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit z);
    ctl_t  e;
    string t;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      opcode = op; funct3 = f3; funct7 = f7; alu_zero = z;
      mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      #1;
      chk(t, 32'(got_c), 32'(e));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    #2 rst_n = 1'b0;
    #1 chk("RST_ASYNC", 32'(got_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("RST_REL", 32'(got_c), 32'd0);
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input bit z, input int wf, input int wm, input int halt_n);
    bit h;
    h = model_instr(op, f3, f7, z, wf, wm, halt_n);
    run_q(op, f3, f7, z);
    if (h) do_reset();
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         r;

    repeat (2) @(negedge clk);
    #1 chk("RST_HOLD", 32'(got_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("RST_REL", 32'(got_c), 32'd0);

    do_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0, 3);  // ADD
    do_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, 3);  // SUB
    do_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 0, 0, 3);  // ADDI with imm[10]
    do_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0, 0, 0, 3);  // SRAI
    do_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 3, 3, 3);  // LW with waits
    do_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, 3);  // BEQ taken
    do_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, 3);  // BEQ not taken
    do_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0, 0, 0, 3);  // BNE taken
    do_instr(7'b1100011, 3'b100, 7'b0000000, 1'b1, 0, 0, 3);  // other funct3
    do_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1, 0, 3);  // JAL
    do_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0, 20); // illegal
    do_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 100, 5); // SW timeout
    do_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 3, 3);  // SW ready on 4th cycle
    do_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 4, 0, 3);  // fetch timeout

    for (int k = 0; k < 150; k++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      case (r)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4:       op = 7'b0000011;
        5:       op = 7'b0100011;
        6, 7: begin
          op = 7'b1100011;
          if ($urandom_range(0, 2) != 0) f3 = 3'($urandom_range(0, 1));
        end
        8:       op = 7'b1101111;
        default: begin
          op = 7'($urandom);
          for (int g = 0; g < 50 && legal_op(op); g++) op = 7'($urandom);
          if (legal_op(op)) op = 7'b1111111;
        end
      endcase
      do_instr(op, f3, f7, 1'($urandom_range(0, 1)), rand_wait(), rand_wait(), 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
